// File: rtl/serial_and16_pkg.sv
// Shared constants and state encoding for the bit-serial 16-bit AND unit.
package serial_and16_pkg;

  localparam int unsigned SA_WIDTH = 16;
  localparam int unsigned SA_CNT_W = $clog2(SA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_and16_andgate.sv
// One-bit AND cell, time-multiplexed by serial_and16 across the word.
module andGate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = i_a & i_b;

endmodule

// File: rtl/serial_and16.sv
// Bit-serial bitwise AND: accepts an operand pair, computes one bit per
// cycle LSB first through a single andGate, then holds the word until taken.
module serial_and16
  import serial_and16_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_x_sr;
  logic [WIDTH-1:0] r_y_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_bit;

  // Single shared bit-slice: AND of the current operand LSBs.
  andGate u_and (
    .i_a (r_x_sr[0]),
    .i_b (r_y_sr[0]),
    .o_y (w_bit)
  );

  // Control FSM and datapath; handshake flags are registered alongside state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_x_sr      <= '0;
      r_y_sr      <= '0;
      r_res_sr    <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x_sr     <= x;
            r_y_sr     <= y;
            r_cnt      <= '0;
            r_state    <= ST_SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_SHIFT: begin
          r_x_sr   <= r_x_sr >> 1;
          r_y_sr   <= r_y_sr >> 1;
          r_res_sr <= {w_bit, r_res_sr[WIDTH-1:1]};
          if (r_cnt == LAST_CNT) begin
            // Last bit: publish the completed word directly, bypassing the shifter.
            r_out       <= {w_bit, r_res_sr[WIDTH-1:1]};
            r_cnt       <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // No bypass: in_ready only rises the cycle after the result is taken.
          if (out_ready && r_out_valid) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_and16.sv
// Directed self-checking bench for serial_and16.
module tb_serial_and16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  serial_and16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one operand pair in IDLE; the handshake edge is the next rising edge.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    x = a;
    y = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    x = 16'h0000;
    y = 16'h0000;
    chk({tag, " busy after capture"}, 32'(busy), 32'd1);
    chk({tag, " in_ready after capture"}, 32'(in_ready), 32'd0);
  endtask

  // Count edges after the handshake until out_valid; optionally toggle noise inputs.
  task automatic wait_result(input string tag, input logic [15:0] exp, input bit noise);
    int lat;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (noise) begin
        in_valid = k[0];
        x = 16'hFFFF;
        y = 16'hFFFF;
      end
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd16);
    chk({tag, " out"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int          cyc_last;
    int          idx_in;
    int          idx_out;
    bit          hs;
    logic [15:0] vx [3];
    logic [15:0] vy [3];
    logic [15:0] ve [3];

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 16'h0000;
    y         = 16'h0000;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out", 32'(out), 32'd0);

    // All ones with consumer always ready
    out_ready = 1'b1;
    start_op("ffff", 16'hFFFF, 16'hFFFF);
    wait_result("ffff", 16'hFFFF, 1'b0);
    step();
    chk("ffff idle in_ready", 32'(in_ready), 32'd1);
    chk("ffff idle out_valid", 32'(out_valid), 32'd0);
    chk("ffff out retained", 32'(out), 32'hFFFF);

    // Mixed pattern, consumer stalls 5 cycles in DONE while inputs are noisy
    out_ready = 1'b0;
    start_op("1234", 16'h1234, 16'h0F0F);
    wait_result("1234", 16'h0204, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x = 16'h5555;
      y = 16'h5555;
      step();
      chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d out", i), 32'(out), 32'h0204);
      chk($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall release in_ready", 32'(in_ready), 32'd1);
    chk("stall release out_valid", 32'(out_valid), 32'd0);
    chk("stall release out", 32'(out), 32'h0204);

    // Inputs toggled while busy must not disturb the operation
    start_op("00ff", 16'h00FF, 16'h0F0F);
    wait_result("00ff noisy", 16'h000F, 1'b1);
    step();
    chk("noisy idle busy", 32'(busy), 32'd0);

    // Reset at bit count 7 aborts with no partial result
    start_op("abort", 16'hAAAA, 16'hFFFF);
    for (int k = 0; k < 7; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out", 32'(out), 32'd0);
    for (int k = 0; k < 20; k++) step();
    chk("abort no late valid", 32'(out_valid), 32'd0);

    // Reset wins over a simultaneous input handshake
    x = 16'hFFFF;
    y = 16'hFFFF;
    in_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst prio busy", 32'(busy), 32'd0);
    chk("rst prio in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream with both handshakes held high
    vx[0] = 16'h1234; vy[0] = 16'h0F0F; ve[0] = 16'h0204;
    vx[1] = 16'hFFFF; vy[1] = 16'h00FF; ve[1] = 16'h00FF;
    vx[2] = 16'hA5A5; vy[2] = 16'h5AFF; ve[2] = 16'h00A5;
    idx_in   = 0;
    idx_out  = 0;
    cyc_last = 0;
    out_ready = 1'b1;
    x = vx[0];
    y = vy[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      hs = in_ready && in_valid;
      step();
      if (hs) begin
        idx_in++;
        if (idx_in < 3) begin
          x = vx[idx_in];
          y = vy[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        chk($sformatf("b2b%0d out", idx_out), 32'(out), 32'(ve[idx_out]));
        if (idx_out == 0) chk("b2b0 first latency", 32'(cyc), 32'd16);
        else chk($sformatf("b2b%0d period", idx_out), 32'(cyc - cyc_last), 32'd18);
        cyc_last = cyc;
        idx_out++;
        if (idx_out == 3) break;
      end
    end
    chk("b2b result count", 32'(idx_out), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_and16.md
SERIAL_AND16 -- requirements
Module: serial_and16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result word width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair on x/y is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 The block SHALL have port x, input, WIDTH bits: first operand.
REQ-007 The block SHALL have port y, input, WIDTH bits: second operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result on out is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port out, output, WIDTH bits: the bitwise AND result x&y.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT and DONE.

Function
REQ-012 The block SHALL use the FSM states IDLE, SHIFT and DONE.
REQ-013 The block SHALL drive in_ready high only in IDLE; an input handshake occurs when in_valid and in_ready are both high at a rising edge.
REQ-014 On an input handshake the block SHALL capture x and y into operand shift registers, clear the 4-bit bit counter to 0, and move to SHIFT.
REQ-015 In SHIFT the block SHALL process exactly one bit per cycle, LSB first, shifting x_sr[0]&y_sr[0] into the MSB of a result shift register while shifting both operand registers right by one.
REQ-016 The bit counter SHALL increment once per SHIFT cycle; at count 15 the block SHALL load the completed result into the out register, move to DONE, and wrap the counter to 0.
REQ-017 Latency SHALL be fixed: out_valid rises exactly WIDTH (16) cycles after the input handshake edge, independent of operand values.
REQ-018 In DONE the block SHALL hold out_valid high and keep out stable until an output handshake, i.e. out_valid and out_ready both high at a rising edge.
REQ-019 On an output handshake the block SHALL move to IDLE; in_ready SHALL be low in that handshake cycle (no bypass), giving a minimum of 18 cycles per operation.
REQ-020 out SHALL retain the last result after the output handshake until the next completion overwrites it.
REQ-021 The block SHALL ignore x, y and in_valid outside IDLE, and SHALL ignore out_ready outside DONE.
REQ-022 All datapath widths SHALL equal WIDTH with no truncation or extension; the counter SHALL be clog2(WIDTH) bits.

Reset
REQ-023 When reset is high at a rising edge, the block SHALL enter IDLE, regardless of its current state, and clear the counter, operand registers, result shift register and out register to 0.
REQ-024 After reset the outputs SHALL be in_ready=1, out_valid=0, busy=0 and out=0.
REQ-025 A reset asserted mid-SHIFT or in DONE SHALL abort the operation with no partial result appearing on out.
REQ-026 Reset SHALL take priority over any handshake occurring at the same edge.

Structure
REQ-027 A shared package SHALL hold WIDTH=16, the counter width, and the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
REQ-028 The one-bit datapath SHALL be a single instance of the existing andGate sub-module, time-multiplexed over the word width.

Verification
REQ-029 The bench SHALL drive x=16'hFFFF, y=16'hFFFF, out_ready=1; required response: out_valid high 16 cycles after the handshake with out=16'hFFFF.
REQ-030 The bench SHALL drive x=16'h1234, y=16'h0F0F; required response: out=16'h0204.
REQ-031 The bench SHALL hold out_ready=0 for 5 cycles in DONE; required response: out_valid and out stay constant, in_ready stays 0, and the block returns to IDLE only after out_ready=1.
REQ-032 The bench SHALL assert reset at bit count 7 of x=16'hAAAA, y=16'hFFFF; required response: the next cycle shows in_ready=1, out_valid=0, busy=0, out=0.
REQ-033 The bench SHALL offer back-to-back operands with in_valid and out_ready held high; required response: one result every 18 cycles, in order, each equal to x&y.
REQ-034 The bench SHALL toggle in_valid while busy; required response: no capture occurs and the result is unchanged.
